// File: rtl/softmax_tree_pkg.sv
// Shared types and constants for the softmax tree datapath blocks.
package softmax_tree_pkg;

  // Operand format: signed Q6.10 fixed point.
  localparam int DATA_W = 16;
  localparam int FRAC_W = 10;

  // Widest requester index any arbiter in the tree needs (up to 8 requesters).
  localparam int TAG_MAX_W = 3;

  typedef logic signed [DATA_W-1:0] q6_10_t;

  // One slot of an in-flight tag pipeline: valid flag plus requester index.
  typedef struct packed {
    logic                 vld;
    logic [TAG_MAX_W-1:0] tag;
  } tag_entry_t;

  // Requester-index width; a single requester still gets a 1-bit index.
  function automatic int tag_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// searching upward from (ptr + 1) mod NUM_REQ. Grant is one-hot or zero.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = softmax_tree_pkg::tag_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Rotating priority search; the requester just after ptr has top priority.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stage1_log2_arbiter.sv
// Shares one stage1_log2_approx unit among NUM_REQ requesters. Accepts one
// operand pair per enabled cycle, tracks the issuing requester through a tag
// pipeline matched to the stage latency, and steers each result back to it.
module stage1_log2_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 16,
  parameter int STAGE_LAT = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_in0,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_in1,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_stg_en,
  output logic                      o_stg_valid,
  output logic [DATA_W-1:0]         o_stg_in0,
  output logic [DATA_W-1:0]         o_stg_in1,
  input  logic                      i_stg_valid,
  input  logic [DATA_W-1:0]         i_stg_log2_in0,
  input  logic [DATA_W-1:0]         i_stg_in0_byp,
  input  logic [DATA_W-1:0]         i_stg_in1_byp,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_log2,
  output logic [DATA_W-1:0]         o_rsp_in0,
  output logic [DATA_W-1:0]         o_rsp_in1,
  output logic                      o_busy,
  output logic                      o_err_orphan
);

  import softmax_tree_pkg::tag_entry_t;
  import softmax_tree_pkg::TAG_MAX_W;
  import softmax_tree_pkg::tag_width;

  localparam int TAG_W  = tag_width(NUM_REQ);
  localparam int PIPE_D = STAGE_LAT + 1;

  // Arbitration
  logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant;
  logic               arb_en;
  logic               grant_any;
  logic [TAG_W-1:0]   grant_idx;
  logic [DATA_W-1:0]  sel_in0, sel_in1;

  // Stage drive registers
  logic              stg_valid_q, stg_valid_d;
  logic [DATA_W-1:0] stg_in0_q, stg_in0_d;
  logic [DATA_W-1:0] stg_in1_q, stg_in1_d;

  // Tag pipeline; entry 0 travels with o_stg_valid, the tail meets i_stg_valid
  tag_entry_t pipe_q [PIPE_D];
  tag_entry_t pipe_d [PIPE_D];
  tag_entry_t tail;

  // Response and error registers
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_log2_q, rsp_log2_d;
  logic [DATA_W-1:0]  rsp_in0_q, rsp_in0_d;
  logic [DATA_W-1:0]  rsp_in1_q, rsp_in1_d;
  logic               err_orphan_q, err_orphan_d;

  // No grant may be issued while reset is held, even though the grant is
  // combinational and would otherwise follow i_en immediately.
  assign arb_en = i_en & ~i_rst;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (TAG_W)
  ) u_rr_arbiter (
    .req   (i_req_valid),
    .ptr   (rr_ptr_q),
    .en    (arb_en),
    .grant (grant)
  );

  // Encode the one-hot grant and mux the winning operand pair.
  always_comb begin
    grant_idx = '0;
    sel_in0   = '0;
    sel_in1   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        grant_idx = TAG_W'(k);
        sel_in0   = i_req_in0[k*DATA_W +: DATA_W];
        sel_in1   = i_req_in1[k*DATA_W +: DATA_W];
      end
    end
    grant_any = |grant;
  end

  // Issue side: pointer, stage drive and tag pipe all freeze with the stage.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    stg_valid_d = stg_valid_q;
    stg_in0_d   = stg_in0_q;
    stg_in1_d   = stg_in1_q;
    pipe_d      = pipe_q;
    if (i_en) begin
      stg_valid_d = grant_any;
      if (grant_any) begin
        rr_ptr_d  = grant_idx;
        stg_in0_d = sel_in0;
        stg_in1_d = sel_in1;
      end
      pipe_d[0] = '{vld: grant_any, tag: TAG_MAX_W'(grant_idx)};
      for (int k = 1; k < PIPE_D; k++) begin
        pipe_d[k] = pipe_q[k-1];
      end
    end
  end

  assign tail = pipe_q[STAGE_LAT];

  // Return side: route a tagged result to its requester, flag any mismatch.
  // Capture is gated by i_en because a frozen stage keeps o_valid high.
  always_comb begin
    rsp_valid_d  = '0;
    rsp_log2_d   = rsp_log2_q;
    rsp_in0_d    = rsp_in0_q;
    rsp_in1_d    = rsp_in1_q;
    err_orphan_d = err_orphan_q;
    if (i_en) begin
      if (i_stg_valid && tail.vld) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (tail.tag == TAG_MAX_W'(k)) begin
            rsp_valid_d[k] = 1'b1;
          end
        end
        rsp_log2_d = i_stg_log2_in0;
        rsp_in0_d  = i_stg_in0_byp;
        rsp_in1_d  = i_stg_in1_byp;
      end else if (i_stg_valid != tail.vld) begin
        err_orphan_d = 1'b1;
      end
    end
  end

  // Issue-side state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (i_rst) begin
      rr_ptr_q    <= TAG_W'(NUM_REQ - 1);
      stg_valid_q <= 1'b0;
      stg_in0_q   <= '0;
      stg_in1_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      stg_valid_q <= stg_valid_d;
      stg_in0_q   <= stg_in0_d;
      stg_in1_q   <= stg_in1_d;
    end
  end

  // Tag pipeline registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: this array is control state (the valid bits), not a data memory,
    // so every entry is reset to drop in-flight tags.
    if (i_rst) begin
      for (int k = 0; k < PIPE_D; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE_D; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  // Response and sticky error registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_valid_q  <= '0;
      rsp_log2_q   <= '0;
      rsp_in0_q    <= '0;
      rsp_in1_q    <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_log2_q   <= rsp_log2_d;
      rsp_in0_q    <= rsp_in0_d;
      rsp_in1_q    <= rsp_in1_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // Busy whenever any tag slot (including the stage-input slot) is occupied.
  always_comb begin
    o_busy = 1'b0;
    for (int k = 0; k < PIPE_D; k++) begin
      o_busy = o_busy | pipe_q[k].vld;
    end
  end

  assign o_req_ready  = grant;
  assign o_stg_en     = i_en;
  assign o_stg_valid  = stg_valid_q;
  assign o_stg_in0    = stg_in0_q;
  assign o_stg_in1    = stg_in1_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_log2   = rsp_log2_q;
  assign o_rsp_in0    = rsp_in0_q;
  assign o_rsp_in1    = rsp_in1_q;
  assign o_err_orphan = err_orphan_q;

endmodule
